alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU, for the next-generation datapath.
- Width is set by a parameter.
- Holds its own carry flag across operations instead of taking carry in combinationally.
- Adds subtract, a zero flag, and multi-cycle barrel-free shifts (one bit per cycle) under a start/busy/done handshake.
- Sits between the register file read ports and the writeback mux; the sequencer stalls on busy.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 4 to 64).
- SHW, $clog2(WIDTH), width of the shift-count field taken from b[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- aluc  input  4  operation code, latched on accepted start.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B / shift count, latched on accepted start.
- z  output  WIDTH  registered result; holds its value until the next completion that writes it.
- cy_out  output  1  registered carry flag (internal state, feeds ADC).
- zf  output  1  registered zero flag, 1 when the value written to z is all zeros.
- busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  output  1  one-cycle completion pulse.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: z=0, cy_out=0, zf=1, busy=0, done=0, FSM=IDLE, shift counter=0. Reset overrides everything, including an operation in flight; no done is produced for an aborted operation.
- Accept rule: start is accepted only when FSM=IDLE. start while busy=1 is ignored, not queued. done=1 and busy=0 share the completion cycle, so a new start is accepted in that cycle.
- FSM states: IDLE, SHIFT.
- Single-cycle ops (all except 1110/1111): accept at edge N; z/cy_out/zf update and done=1 during cycle N+1; FSM stays IDLE; busy never rises.
- Opcode map (a, b are latched values; "cy" is the cy_out register):
  - 0000 z=a; 0001 z=b; 0010 z=~a; 0011 z=~b.
  - 0100 {cy,z}=a+b (WIDTH+1-bit sum).
  - 0101 {cy,z}=a+b+cy.
  - 0110 z=a|b; 0111 z=a&b.
  - 1000 z=0; 1001 z=1; 1010 z=all ones.
  - 1011 cy=0, z and zf unchanged; 1100 cy=1, z and zf unchanged.
  - 1101 {cy,z}=a+~b+1; cy=1 means no borrow.
  - 1110 SHL logical by b[SHW-1:0].
  - 1111 SHR logical by b[SHW-1:0].
- Carry rule: opcodes other than 0100/0101/1011/1100/1101 and shifts leave cy unchanged.
- zf is updated on every op that writes z.
- Shifts, count k=b[SHW-1:0]:
  - k=0: behaves as a single-cycle op; z=a, cy unchanged, done at N+1.
  - k>0: FSM enters SHIFT at N+1 and busy=1. Each cycle the working register shifts 1 bit and cy takes the bit shifted out (MSB for SHL, LSB for SHR). Zero is shifted in.
  - The counter decrements from k. When it reaches 0, z/zf are written, done=1, busy=0, FSM returns to IDLE.
  - Total latency: done at cycle N+k. cy_out after completion = last bit shifted out.
  - z keeps the previous result throughout the shift; only the final value is written.
- Operand and opcode input changes while busy have no effect on the operation in flight.
- No undefined opcodes: all 16 codes are decoded.

Test Plan:
- Reset, then ADD (aluc=0100) a=16'hFFFF, b=16'h0001 -> next cycle z=16'h0000, cy_out=1, zf=1, done=1 for exactly one cycle.
- Continue with ADC a=16'h0001, b=16'h0001 -> z=16'h0003, cy_out=0, zf=0.
- SEC (1100) then AND a=16'hF0F0, b=16'h0FF0 -> z=16'h00F0, cy_out stays 1.
- SUB a=16'h0003, b=16'h0005 -> z=16'hFFFE, cy_out=0 (borrow).
- SUB a=5, b=5 -> z=0, cy_out=1, zf=1.
- SHL a=16'h8001, b=3 -> busy=1 for 2 cycles; done at N+3; z=16'h0008; cy_out=0 (last bit out is bit 13 of a).
- SHR a=16'h0001, b=1 -> z=0, cy_out=1, zf=1.
- start with ADD pulsed during a SHL k=15 -> ignored; only one done, at N+15.
- reset asserted at cycle N+5 of that shift -> z=0, cy_out=0, busy=0, no done.
- Shift with k=0, a=16'h1234 -> z=16'h1234, done at N+1, busy never high, cy unchanged.
- Back-to-back: new start in the done cycle is accepted.

Source files
------------

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_if
// Brief   : Request/result bundle between the sequencer and alu_seq.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [3:0]       aluc;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] z;
   logic             cy_out;
   logic             zf;
   logic             busy;
   logic             done;

   modport master (
      output start, aluc, a, b,
      input  z, cy_out, zf, busy, done
   );

   modport slave (
      input  start, aluc, a, b,
      output z, cy_out, zf, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Brief   : Registered ALU with carry state and one-bit-per-cycle shifts.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  wire logic  clk,
   input  wire logic  reset,
   alu_seq_if.slave   bus
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   localparam logic [3:0] c_OP_PASSA = 4'b0000;
   localparam logic [3:0] c_OP_PASSB = 4'b0001;
   localparam logic [3:0] c_OP_NOTA  = 4'b0010;
   localparam logic [3:0] c_OP_NOTB  = 4'b0011;
   localparam logic [3:0] c_OP_ADD   = 4'b0100;
   localparam logic [3:0] c_OP_ADC   = 4'b0101;
   localparam logic [3:0] c_OP_OR    = 4'b0110;
   localparam logic [3:0] c_OP_AND   = 4'b0111;
   localparam logic [3:0] c_OP_ZERO  = 4'b1000;
   localparam logic [3:0] c_OP_ONE   = 4'b1001;
   localparam logic [3:0] c_OP_ONES  = 4'b1010;
   localparam logic [3:0] c_OP_CLC   = 4'b1011;
   localparam logic [3:0] c_OP_SEC   = 4'b1100;
   localparam logic [3:0] c_OP_SUB   = 4'b1101;
   localparam logic [3:0] c_OP_SHL   = 4'b1110;
   localparam logic [3:0] c_OP_SHR   = 4'b1111;

   localparam logic [SHW-1:0]   c_CNT_ONE = SHW'(1);
   localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

   // Registered state
   state_t           r_state;
   logic [WIDTH-1:0] r_z;
   logic             r_cy;
   logic             r_zf;
   logic             r_done;
   logic [SHW-1:0]   r_cnt;
   logic [WIDTH-1:0] r_work;
   logic             r_dir;

   // Next-state values
   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_z_nxt;
   logic             w_cy_nxt;
   logic             w_zf_nxt;
   logic             w_done_nxt;
   logic [SHW-1:0]   w_cnt_nxt;
   logic [WIDTH-1:0] w_work_nxt;
   logic             w_dir_nxt;

   // Datapath
   logic [WIDTH-1:0] w_res;
   logic             w_wr_z;
   logic [SHW-1:0]   w_k;
   logic [WIDTH-1:0] w_add_b;
   logic             w_add_ci;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_sh_src;
   logic             w_sh_dir;
   logic [WIDTH-1:0] w_sh_res;
   logic             w_sh_out;

   assign w_k = bus.b[SHW-1:0];

   // ADD, ADC and SUB share one adder; SUB is a + ~b + 1.
   always_comb begin
      w_add_b  = bus.b;
      w_add_ci = 1'b0;
      if (bus.aluc == c_OP_SUB) begin
         w_add_b  = ~bus.b;
         w_add_ci = 1'b1;
      end else if (bus.aluc == c_OP_ADC) begin
         w_add_ci = r_cy;
      end
      w_sum = {1'b0, bus.a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_ci};
   end

   // The first shift step happens on the accepting edge, straight from operand A.
   always_comb begin
      w_sh_src = (r_state == S_IDLE) ? bus.a : r_work;
      w_sh_dir = (r_state == S_IDLE) ? bus.aluc[0] : r_dir;
      if (w_sh_dir) begin
         w_sh_res = {1'b0, w_sh_src[WIDTH-1:1]};
         w_sh_out = w_sh_src[0];
      end else begin
         w_sh_res = {w_sh_src[WIDTH-2:0], 1'b0};
         w_sh_out = w_sh_src[WIDTH-1];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_z_nxt     = r_z;
      w_cy_nxt    = r_cy;
      w_zf_nxt    = r_zf;
      w_done_nxt  = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_work_nxt  = r_work;
      w_dir_nxt   = r_dir;
      w_res       = '0;
      w_wr_z      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_done_nxt = 1'b1;
               case (bus.aluc)
                  c_OP_PASSA: begin w_res = bus.a;  w_wr_z = 1'b1; end
                  c_OP_PASSB: begin w_res = bus.b;  w_wr_z = 1'b1; end
                  c_OP_NOTA:  begin w_res = ~bus.a; w_wr_z = 1'b1; end
                  c_OP_NOTB:  begin w_res = ~bus.b; w_wr_z = 1'b1; end
                  c_OP_ADD, c_OP_ADC, c_OP_SUB: begin
                     w_res    = w_sum[WIDTH-1:0];
                     w_cy_nxt = w_sum[WIDTH];
                     w_wr_z   = 1'b1;
                  end
                  c_OP_OR:   begin w_res = bus.a | bus.b; w_wr_z = 1'b1; end
                  c_OP_AND:  begin w_res = bus.a & bus.b; w_wr_z = 1'b1; end
                  c_OP_ZERO: begin w_res = '0;    w_wr_z = 1'b1; end
                  c_OP_ONE:  begin w_res = c_ONE; w_wr_z = 1'b1; end
                  c_OP_ONES: begin w_res = '1;    w_wr_z = 1'b1; end
                  c_OP_CLC:  w_cy_nxt = 1'b0;
                  c_OP_SEC:  w_cy_nxt = 1'b1;
                  c_OP_SHL, c_OP_SHR: begin
                     if (w_k == '0) begin
                        w_res  = bus.a;
                        w_wr_z = 1'b1;
                     end else begin
                        w_cy_nxt = w_sh_out;
                        if (w_k == c_CNT_ONE) begin
                           w_res  = w_sh_res;
                           w_wr_z = 1'b1;
                        end else begin
                           // Multi-step: z keeps its old value until the last step.
                           w_work_nxt  = w_sh_res;
                           w_dir_nxt   = bus.aluc[0];
                           w_cnt_nxt   = w_k - c_CNT_ONE;
                           w_state_nxt = S_SHIFT;
                           w_done_nxt  = 1'b0;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_SHIFT: begin
            w_cy_nxt   = w_sh_out;
            w_work_nxt = w_sh_res;
            w_cnt_nxt  = r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
               w_res       = w_sh_res;
               w_wr_z      = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase

      if (w_wr_z) begin
         w_z_nxt  = w_res;
         w_zf_nxt = (w_res == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_z     <= '0;
         r_cy    <= 1'b0;
         r_zf    <= 1'b1;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_work  <= '0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_z     <= w_z_nxt;
         r_cy    <= w_cy_nxt;
         r_zf    <= w_zf_nxt;
         r_done  <= w_done_nxt;
         r_cnt   <= w_cnt_nxt;
         r_work  <= w_work_nxt;
         r_dir   <= w_dir_nxt;
      end
   end

   assign bus.z      = r_z;
   assign bus.cy_out = r_cy;
   assign bus.zf     = r_zf;
   assign bus.done   = r_done;
   assign bus.busy   = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Brief   : Directed self-checking bench for alu_seq (WIDTH=16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   alu_seq_if #(.WIDTH(16)) bus ();

   alu_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge and wait (bounded) for done; lat counts cycles after accept.
   task automatic run_op(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                         output int lat, output int nbusy);
      @(negedge clk);
      bus.start = 1'b1;
      bus.aluc  = op;
      bus.a     = va;
      bus.b     = vb;
      lat   = 0;
      nbusy = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         lat++;
         if (bus.busy) nbusy++;
      end while (!bus.done && lat < 40);
   endtask

   task automatic run_vec(input string tag, input logic [3:0] op, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] ez, input logic ecy,
                          input logic ezf, input int elat, input int ebusy);
      int lat;
      int nbusy;
      run_op(op, va, vb, lat, nbusy);
      check_val({tag, "_z"},    bus.z,      ez);
      check_val({tag, "_cy"},   bus.cy_out, ecy);
      check_val({tag, "_zf"},   bus.zf,     ezf);
      check_val({tag, "_lat"},  lat,        elat);
      check_val({tag, "_busy"}, nbusy,      ebusy);
      @(negedge clk);
      check_val({tag, "_done_drop"}, bus.done, 1'b0);
   endtask

   initial begin
      int ndone;
      int dlat;
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.aluc  = 4'h0;
      bus.a     = 16'h0;
      bus.b     = 16'h0;
      repeat (3) @(negedge clk);
      check_val("rst_z",    bus.z,      16'h0000);
      check_val("rst_cy",   bus.cy_out, 1'b0);
      check_val("rst_zf",   bus.zf,     1'b1);
      check_val("rst_busy", bus.busy,   1'b0);
      check_val("rst_done", bus.done,   1'b0);
      reset = 1'b0;

      //       tag      op       a         b         z         cy    zf   lat busy
      run_vec("add",   4'b0100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("adc",   4'b0101, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1, 0);
      run_vec("sec",   4'b1100, 16'h0000, 16'h0000, 16'h0003, 1'b1, 1'b0, 1, 0);
      run_vec("and",   4'b0111, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1, 1'b0, 1, 0);
      run_vec("sub1",  4'b1101, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1, 0);
      run_vec("sub2",  4'b1101, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("shl3",  4'b1110, 16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 3, 2);
      run_vec("shr1",  4'b1111, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("nota",  4'b0010, 16'h00FF, 16'h1111, 16'hFF00, 1'b1, 1'b0, 1, 0);
      run_vec("notb",  4'b0011, 16'h2222, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("or",    4'b0110, 16'h1200, 16'h0034, 16'h1234, 1'b1, 1'b0, 1, 0);
      run_vec("zero",  4'b1000, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("one",   4'b1001, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1, 0);
      run_vec("ones",  4'b1010, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1, 0);
      run_vec("clc",   4'b1011, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1, 0);
      run_vec("adc0",  4'b0101, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1, 0);
      run_vec("passa", 4'b0000, 16'hA5A5, 16'h0000, 16'hA5A5, 1'b0, 1'b0, 1, 0);
      run_vec("passb", 4'b0001, 16'h0000, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1, 0);
      run_vec("shr4",  4'b1111, 16'hF000, 16'h0004, 16'h0F00, 1'b0, 1'b0, 4, 3);
      run_vec("addov", 4'b0100, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("shl1",  4'b1110, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1, 0);

      // Back-to-back: second start issued in the done cycle of the first.
      @(negedge clk);
      bus.start = 1'b1; bus.aluc = 4'b1110; bus.a = 16'h0001; bus.b = 16'h0002;
      @(negedge clk);
      bus.start = 1'b0;
      check_val("b2b_busy", bus.busy, 1'b1);
      @(negedge clk);
      check_val("b2b_done1", bus.done, 1'b1);
      check_val("b2b_z1",    bus.z,    16'h0004);
      bus.start = 1'b1; bus.aluc = 4'b0001; bus.b = 16'h5A5A;
      @(negedge clk);
      bus.start = 1'b0;
      check_val("b2b_done2", bus.done, 1'b1);
      check_val("b2b_z2",    bus.z,    16'h5A5A);

      // SHL by 15 with an ADD request pulsed mid-flight.
      @(negedge clk);
      bus.start = 1'b1; bus.aluc = 4'b1110; bus.a = 16'h0003; bus.b = 16'h000F;
      ndone = 0;
      dlat  = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (c == 2) check_val("shl15_zhold", bus.z, 16'h5A5A);
         if (c == 4) begin
            bus.start = 1'b1; bus.aluc = 4'b0100; bus.a = 16'h0001; bus.b = 16'h0001;
         end
         if (bus.done) begin
            ndone++;
            dlat = c;
         end
      end
      check_val("shl15_ndone", ndone, 1);
      check_val("shl15_lat",   dlat,  15);
      check_val("shl15_z",     bus.z, 16'h8000);
      check_val("shl15_cy",    bus.cy_out, 1'b1);

      // Reset aborts a shift in flight.
      @(negedge clk);
      bus.start = 1'b1; bus.aluc = 4'b1110; bus.a = 16'h0003; bus.b = 16'h000F;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      check_val("abort_busy_pre", bus.busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("abort_z",    bus.z,      16'h0000);
      check_val("abort_cy",   bus.cy_out, 1'b0);
      check_val("abort_busy", bus.busy,   1'b0);
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check_val("abort_ndone", ndone, 0);

      // Shift count zero: upper bits of b are ignored, behaves as pass-A.
      run_vec("sec2",  4'b1100, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1, 0);
      run_vec("shl0",  4'b1110, 16'h1234, 16'h0010, 16'h1234, 1'b1, 1'b0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
